wb_uart_bridge: RTL and testbench

// Debug UART-to-Wishbone master. Parses framed read/write commands from a serial link
// (DEBUG_RX/DEBUG_TX) and issues single classic Wishbone cycles on the SoC bus.
// It is the initiating end of the bus that wb_power_interface responds on, giving host-side

---
 rtl/wb_uart_bridge.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_wb_uart_bridge.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_bridge.sv
// wb_uart_bridge: debug UART-to-Wishbone master.
// Receives framed commands on uart_rx_i and issues one classic Wishbone cycle per frame.
// It answers each frame on uart_tx_o.
//   'W' ADR[4] DAT[4] -> write,    reply 'K'
//   'R' ADR[4]        -> read,     reply DAT[4] (MSB first)
//   other first byte  -> no cycle, reply '?'
//   ack timeout       -> reply 'E'
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   uart_rx_i / uart_tx_o   8N1 serial in / out, idle high
//   wb_adr_o/dat_o/dat_i    Wishbone address, write data, read data (32 bit)
//   wb_sel_o/we_o/cyc_o/stb_o/ack_i  Wishbone control
//   busy_o                  high from accepted command byte until reply stop bit ends
module wb_uart_bridge #(
   parameter int unsigned CLKS_PER_BIT = 694,
   parameter int unsigned ACK_TIMEOUT  = 255,
   parameter int unsigned BYTE_TIMEOUT = 80000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        uart_rx_i,
   output logic        uart_tx_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        busy_o
);

   localparam int unsigned BIT_CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF   = CLKS_PER_BIT / 2;
   localparam int unsigned ACK_CW = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned TMO_CW = $clog2(BYTE_TIMEOUT + 1);

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_UNK = 8'h3F;
   localparam logic [7:0] RSP_ERR = 8'h45;

   localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(CLKS_PER_BIT - 1);
   localparam logic [BIT_CW-1:0] BIT_HALF = BIT_CW'(HALF - 1);

   // ---------------- UART receiver ----------------
   logic              rx_s1, rx_s2, rx_prev, rx_active;
   logic [BIT_CW-1:0] rx_cnt;
   logic [3:0]        rx_bit;
   logic [7:0]        rx_shift, rx_data;
   logic              rx_valid, rx_ferr;

   // Synchronise, detect start edge, sample mid-bit; rx_valid / rx_ferr are one-cycle pulses.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         rx_active <= 1'b0;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_ferr   <= 1'b0;
      end else begin
         rx_s1    <= uart_rx_i;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (!rx_active) begin
            if (rx_prev && !rx_s2) begin
               rx_active <= 1'b1;
               rx_cnt    <= BIT_HALF;
               rx_bit    <= '0;
            end
         end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
         end else begin
            rx_cnt <= BIT_LAST;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
               // start bit gone high again at mid-bit: treat as a glitch
               if (rx_s2) rx_active <= 1'b0;
            end else if (rx_bit == 4'd9) begin
               rx_active <= 1'b0;
               if (rx_s2) begin
                  rx_valid <= 1'b1;
                  rx_data  <= rx_shift;
               end else begin
                  rx_ferr  <= 1'b1;
               end
            end else begin
               rx_shift <= {rx_s2, rx_shift[7:1]};
            end
         end
      end
   end

   // ---------------- UART transmitter ----------------
   logic              tx_active;
   logic [BIT_CW-1:0] tx_cnt;
   logic [3:0]        tx_bit;
   logic [8:0]        tx_shift;
   logic              tx_done_c, tx_ready_c, tx_load_c;
   logic [7:0]        tx_byte_c;

   // A new byte may be loaded on the very cycle the stop bit ends, so replies have no gaps.
   assign tx_done_c  = tx_active && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);
   assign tx_ready_c = !tx_active || tx_done_c;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tx_active <= 1'b0;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '1;
         uart_tx_o <= 1'b1;
      end else if (tx_load_c) begin
         tx_active <= 1'b1;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= {1'b1, tx_byte_c};
         uart_tx_o <= 1'b0;
      end else if (tx_active) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_active <= 1'b0;
               uart_tx_o <= 1'b1;
            end else begin
               tx_bit    <= tx_bit + 4'd1;
               uart_tx_o <= tx_shift[0];
               tx_shift  <= {1'b1, tx_shift[8:1]};
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   // ---------------- Command FSM ----------------
   typedef enum logic [2:0] {IDLE, GET_ADR, GET_DAT, WB_CYC, SEND} state_t;

   state_t            state, state_n;
   logic              is_wr, is_wr_n;
   logic [31:0]       adr_q, adr_n, dat_q, dat_n, resp_q, resp_n;
   logic [1:0]        byte_cnt, byte_cnt_n;
   logic [2:0]        resp_len, resp_len_n, sent, sent_n;
   logic [TMO_CW-1:0] tmo, tmo_n;
   logic [ACK_CW-1:0] ack_cnt, ack_cnt_n;
   logic              cyc_n, we_n, busy_n;
   logic [3:0]        sel_n;
   logic [31:0]       wb_adr_n, wb_dat_n;

   // State and datapath registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         is_wr    <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         resp_q   <= '0;
         byte_cnt <= '0;
         resp_len <= '0;
         sent     <= '0;
         tmo      <= '0;
         ack_cnt  <= '0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_sel_o <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         busy_o   <= 1'b0;
      end else begin
         state    <= state_n;
         is_wr    <= is_wr_n;
         adr_q    <= adr_n;
         dat_q    <= dat_n;
         resp_q   <= resp_n;
         byte_cnt <= byte_cnt_n;
         resp_len <= resp_len_n;
         sent     <= sent_n;
         tmo      <= tmo_n;
         ack_cnt  <= ack_cnt_n;
         wb_cyc_o <= cyc_n;
         wb_stb_o <= cyc_n;
         wb_we_o  <= we_n;
         wb_sel_o <= sel_n;
         wb_adr_o <= wb_adr_n;
         wb_dat_o <= wb_dat_n;
         busy_o   <= busy_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n    = state;
      is_wr_n    = is_wr;
      adr_n      = adr_q;
      dat_n      = dat_q;
      resp_n     = resp_q;
      byte_cnt_n = byte_cnt;
      resp_len_n = resp_len;
      sent_n     = sent;
      tmo_n      = tmo;
      ack_cnt_n  = ack_cnt;
      cyc_n      = wb_cyc_o;
      we_n       = wb_we_o;
      sel_n      = wb_sel_o;
      wb_adr_n   = wb_adr_o;
      wb_dat_n   = wb_dat_o;
      busy_n     = busy_o;
      tx_load_c  = 1'b0;
      tx_byte_c  = resp_q[31:24];

      case (state)
         IDLE: begin
            if (rx_valid) begin
               busy_n     = 1'b1;
               byte_cnt_n = '0;
               tmo_n      = '0;
               if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  is_wr_n = (rx_data == CMD_WR);
                  state_n = GET_ADR;
               end else begin
                  resp_n     = {RSP_UNK, 24'h0};
                  resp_len_n = 3'd1;
                  sent_n     = '0;
                  state_n    = SEND;
               end
            end
         end

         GET_ADR, GET_DAT: begin
            if (rx_ferr) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else if (rx_valid) begin
               tmo_n      = '0;
               byte_cnt_n = byte_cnt + 2'd1;
               if (state == GET_ADR) adr_n = {adr_q[23:0], rx_data};
               else                  dat_n = {dat_q[23:0], rx_data};
               if (byte_cnt == 2'd3) begin
                  if (state == GET_ADR && is_wr) begin
                     state_n = GET_DAT;
                  end else begin
                     // all bus signals go up together on the entry edge
                     state_n   = WB_CYC;
                     cyc_n     = 1'b1;
                     we_n      = is_wr;
                     sel_n     = 4'hF;
                     wb_adr_n  = adr_n;
                     wb_dat_n  = dat_n;
                     ack_cnt_n = '0;
                  end
               end
            end else if (tmo == TMO_CW'(BYTE_TIMEOUT - 1)) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               tmo_n = tmo + 1'b1;
            end
         end

         WB_CYC: begin
            // ack_cnt == k-1 in the k-th cycle of cyc_o, so an ack in cycle ACK_TIMEOUT still wins
            if (wb_ack_i) begin
               cyc_n      = 1'b0;
               we_n       = 1'b0;
               sel_n      = '0;
               resp_n     = is_wr ? {RSP_OK, 24'h0} : wb_dat_i;
               resp_len_n = is_wr ? 3'd1 : 3'd4;
               sent_n     = '0;
               state_n    = SEND;
            end else if (ack_cnt == ACK_CW'(ACK_TIMEOUT - 1)) begin
               cyc_n      = 1'b0;
               we_n       = 1'b0;
               sel_n      = '0;
               resp_n     = {RSP_ERR, 24'h0};
               resp_len_n = 3'd1;
               sent_n     = '0;
               state_n    = SEND;
            end else begin
               ack_cnt_n = ack_cnt + 1'b1;
            end
         end

         SEND: begin
            if (tx_ready_c) begin
               if (sent != resp_len) begin
                  tx_load_c = 1'b1;
                  resp_n    = {resp_q[23:0], 8'h00};
                  sent_n    = sent + 3'd1;
               end else if (tx_done_c) begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_uart_bridge.sv
// tb_wb_uart_bridge: directed testbench for wb_uart_bridge.
// It provides a bit-banged UART host, a Wishbone slave model with programmable ack delay,
// and a UART reply decoder. Expected values are hand-computed constants.
module tb_wb_uart_bridge;

   localparam int unsigned CPB    = 8;
   localparam int unsigned ACK_TO = 16;
   localparam int unsigned BYTE_TO = 200;
   localparam int unsigned CLK_NS = 10;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic        uart_rx_i;
   logic        uart_tx_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = 32'h0;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i = 1'b0;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   wb_uart_bridge #(
      .CLKS_PER_BIT (CPB),
      .ACK_TIMEOUT  (ACK_TO),
      .BYTE_TIMEOUT (BYTE_TO)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .uart_rx_i (uart_rx_i),
      .uart_tx_o (uart_tx_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_dat_i  (wb_dat_i),
      .wb_sel_o  (wb_sel_o),
      .wb_we_o   (wb_we_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_ack_i  (wb_ack_i),
      .busy_o    (busy_o)
   );

   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   // Wishbone slave model: acks in cycle ack_delay+1 of cyc_o (never if negative).
   int          ack_delay = 1;
   bit          stray_ack = 1'b0;
   logic [31:0] rd_data = 32'h0;
   int          txn_count = 0;
   int          cyc_cnt = 0;
   int          last_cyc_len = 0;
   int          stable_err = 0;
   logic [31:0] cap_adr = 32'h0;
   logic [31:0] cap_dat = 32'h0;
   logic        cap_we = 1'b0;
   logic [3:0]  cap_sel = 4'h0;

   always @(negedge wb_clk_i) begin
      if (wb_cyc_o === 1'b1) begin
         cyc_cnt = cyc_cnt + 1;
         if (cyc_cnt == 1) begin
            txn_count = txn_count + 1;
            cap_adr = wb_adr_o;
            cap_dat = wb_dat_o;
            cap_we  = wb_we_o;
            cap_sel = wb_sel_o;
         end else if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat ||
                      wb_we_o !== cap_we || wb_sel_o !== cap_sel) begin
            stable_err = stable_err + 1;
         end
         if (wb_stb_o !== 1'b1) stable_err = stable_err + 1;
         wb_ack_i = (ack_delay >= 0) && (cyc_cnt == ack_delay + 1);
         wb_dat_i = wb_ack_i ? rd_data : 32'h0;
      end else begin
         if (cyc_cnt != 0) last_cyc_len = cyc_cnt;
         cyc_cnt  = 0;
         wb_ack_i = stray_ack;
         wb_dat_i = 32'h0;
      end
   end

   // UART reply decoder: records each byte and the time its start bit began.
   logic [7:0] tx_q[$];
   time        tx_t[$];
   time        t_busy_fall = 0;

   initial begin : tx_mon
      logic [7:0] b;
      time t0;
      forever begin
         @(negedge uart_tx_o);
         t0 = $time;
         repeat (CPB / 2) @(posedge wb_clk_i);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge wb_clk_i);
            b[i] = uart_tx_o;
         end
         repeat (CPB) @(posedge wb_clk_i);
         tx_q.push_back(b);
         tx_t.push_back(t0);
      end
   end

   always @(negedge busy_o) t_busy_fall = $time;

   initial begin
      #(60000 * CLK_NS);
      $display("FAIL watchdog: simulation did not finish within 60000 cycles");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge wb_clk_i);
      uart_rx_i = 1'b0;
      repeat (CPB) @(negedge wb_clk_i);
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = b[i];
         repeat (CPB) @(negedge wb_clk_i);
      end
      uart_rx_i = stop_bit;
      repeat (CPB) @(negedge wb_clk_i);
      uart_rx_i = 1'b1;
   endtask

   task automatic send_frame(input logic [71:0] data, input int n);
      for (int i = 0; i < n; i++) send_byte(data[8*(n-1-i) +: 8], 1'b1);
   endtask

   task automatic clear_q();
      tx_q.delete();
      tx_t.delete();
   endtask

   task automatic wait_reply(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge wb_clk_i);
         if (tx_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reply_wait: got %0d bytes, expected %0d", tx_q.size(), n);
      end
      repeat (10) @(posedge wb_clk_i);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      wb_rst_i  = 1'b1;
      uart_rx_i = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      #1;
      checks++;
      if ({uart_tx_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: tx/cyc/stb/we/busy got %b expected 10000",
                  {uart_tx_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o});
      end
      checks++;
      if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", wb_adr_o); end
      checks++;
      if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
      checks++;
      if (wb_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h expected 0", wb_sel_o); end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (5) @(posedge wb_clk_i);
   endtask

   task automatic test_write();
      int base;
      bit ok;
      ack_delay = 1;
      base = txn_count;
      clear_q();
      send_frame(72'h57_03000004_000000C8, 9);
      wait_reply(1, ok);
      checks++;
      if (txn_count !== base + 1) begin errors++; $display("FAIL write_ncyc: got %0d expected %0d", txn_count - base, 1); end
      checks++;
      if (cap_adr !== 32'h03000004) begin errors++; $display("FAIL write_adr: got %h expected 03000004", cap_adr); end
      checks++;
      if (cap_dat !== 32'h000000C8) begin errors++; $display("FAIL write_dat: got %h expected 000000c8", cap_dat); end
      checks++;
      if ({cap_we, cap_sel} !== 5'b1_1111) begin errors++; $display("FAIL write_we_sel: got %b expected 11111", {cap_we, cap_sel}); end
      checks++;
      if (last_cyc_len !== 2) begin errors++; $display("FAIL write_cyc_len: got %0d expected 2", last_cyc_len); end
      checks++;
      if (stable_err !== 0) begin errors++; $display("FAIL write_stable: got %0d glitches expected 0", stable_err); end
      if (ok) begin
         checks++;
         if (tx_q[0] !== 8'h4B) begin errors++; $display("FAIL write_reply: got %h expected 4b", tx_q[0]); end
      end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL write_busy: got %b expected 0", busy_o); end
   endtask

   task automatic test_read();
      bit ok;
      logic [31:0] got;
      ack_delay = 2;
      rd_data   = 32'hDEADBEEF;
      clear_q();
      send_frame(72'h52_03000008, 5);
      wait_reply(4, ok);
      checks++;
      if (cap_adr !== 32'h03000008) begin errors++; $display("FAIL read_adr: got %h expected 03000008", cap_adr); end
      checks++;
      if ({cap_we, cap_sel} !== 5'b0_1111) begin errors++; $display("FAIL read_we_sel: got %b expected 01111", {cap_we, cap_sel}); end
      if (ok) begin
         got = {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
         checks++;
         if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL read_reply: got %h expected deadbeef", got); end
         checks++;
         if (tx_t[3] - tx_t[0] !== 240 * CLK_NS) begin
            errors++; $display("FAIL read_byte_spacing: got %0t expected %0d", tx_t[3] - tx_t[0], 240 * CLK_NS);
         end
         checks++;
         if (t_busy_fall - tx_t[0] !== 320 * CLK_NS) begin
            errors++; $display("FAIL read_reply_len: got %0t expected %0d", t_busy_fall - tx_t[0], 320 * CLK_NS);
         end
      end
      checks++;
      if (stable_err !== 0) begin errors++; $display("FAIL read_stable: got %0d glitches expected 0", stable_err); end
   endtask

   task automatic test_unknown();
      int base;
      bit ok;
      base = txn_count;
      clear_q();
      stray_ack = 1'b1;
      send_byte(8'h41, 1'b1);
      wait_reply(1, ok);
      stray_ack = 1'b0;
      if (ok) begin
         checks++;
         if (tx_q[0] !== 8'h3F) begin errors++; $display("FAIL unknown_reply: got %h expected 3f", tx_q[0]); end
      end
      checks++;
      if (txn_count !== base) begin errors++; $display("FAIL unknown_ncyc: got %0d expected 0", txn_count - base); end
      ack_delay = 1;
      clear_q();
      send_frame(72'h57_00000010_12345678, 9);
      wait_reply(1, ok);
      checks++;
      if ({cap_adr, cap_dat} !== 64'h00000010_12345678) begin
         errors++; $display("FAIL unknown_next_write: got %h_%h expected 00000010_12345678", cap_adr, cap_dat);
      end
      if (ok) begin
         checks++;
         if (tx_q[0] !== 8'h4B) begin errors++; $display("FAIL unknown_next_reply: got %h expected 4b", tx_q[0]); end
      end
   endtask

   task automatic test_ack_timeout();
      int base;
      bit ok;
      logic [31:0] got;
      // ack in the last allowed cycle still completes
      ack_delay = 15;
      rd_data   = 32'h0BADF00D;
      clear_q();
      send_frame(72'h52_00000020, 5);
      wait_reply(4, ok);
      if (ok) begin
         got = {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
         checks++;
         if (got !== 32'h0BADF00D) begin errors++; $display("FAIL ack_last_reply: got %h expected 0badf00d", got); end
      end
      checks++;
      if (last_cyc_len !== 16) begin errors++; $display("FAIL ack_last_cyc_len: got %0d expected 16", last_cyc_len); end
      // no ack at all
      ack_delay = -1;
      base = txn_count;
      clear_q();
      send_frame(72'h52_00000024, 5);
      wait_reply(1, ok);
      repeat (200) @(posedge wb_clk_i);
      checks++;
      if (last_cyc_len !== 16) begin errors++; $display("FAIL timeout_cyc_len: got %0d expected 16", last_cyc_len); end
      checks++;
      if (txn_count !== base + 1) begin errors++; $display("FAIL timeout_ncyc: got %0d expected 1", txn_count - base); end
      checks++;
      if (tx_q.size() !== 1) begin errors++; $display("FAIL timeout_reply_len: got %0d bytes expected 1", tx_q.size()); end
      if (ok) begin
         checks++;
         if (tx_q[0] !== 8'h45) begin errors++; $display("FAIL timeout_reply: got %h expected 45", tx_q[0]); end
      end
      ack_delay = 1;
   endtask

   task automatic test_byte_timeout();
      int base;
      bit ok;
      base = txn_count;
      clear_q();
      send_frame(72'h570300, 3);
      repeat (300) @(posedge wb_clk_i);
      checks++;
      if (txn_count !== base || tx_q.size() !== 0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL byte_timeout: ncyc %0d reply %0d busy %b expected 0 0 0", txn_count - base, tx_q.size(), busy_o);
      end
      // framing error on the second byte drops the frame immediately
      send_byte(8'h57, 1'b1);
      send_byte(8'h03, 1'b0);
      repeat (20) @(posedge wb_clk_i);
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL framing_abort_busy: got %b expected 0", busy_o); end
      send_frame(72'h57_00000100_CAFEBABE, 9);
      wait_reply(1, ok);
      checks++;
      if (txn_count !== base + 1) begin errors++; $display("FAIL framing_ncyc: got %0d expected 1", txn_count - base); end
      checks++;
      if ({cap_adr, cap_dat} !== 64'h00000100_CAFEBABE) begin
         errors++; $display("FAIL framing_next_write: got %h_%h expected 00000100_cafebabe", cap_adr, cap_dat);
      end
      checks++;
      if (tx_q.size() !== 1) begin errors++; $display("FAIL framing_reply_len: got %0d bytes expected 1", tx_q.size()); end
      if (ok) begin
         checks++;
         if (tx_q[0] !== 8'h4B) begin errors++; $display("FAIL framing_reply: got %h expected 4b", tx_q[0]); end
      end
   endtask

   task automatic test_back_to_back();
      int base;
      bit ok;
      bit fell;
      logic [31:0] got;
      ack_delay = 1;
      rd_data   = 32'h11223344;
      base = txn_count;
      clear_q();
      send_frame(72'h52_00000030, 5);
      fell = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge wb_clk_i);
         if (busy_o === 1'b0) begin
            fell = 1'b1;
            break;
         end
      end
      checks++;
      if (!fell) begin errors++; $display("FAIL b2b_busy_fall: busy %b still high expected 0", busy_o); end
      send_frame(72'h57_00000034_55AA55AA, 9);
      wait_reply(5, ok);
      if (ok) begin
         got = {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
         checks++;
         if (got !== 32'h11223344) begin errors++; $display("FAIL b2b_read_reply: got %h expected 11223344", got); end
         checks++;
         if (tx_q[4] !== 8'h4B) begin errors++; $display("FAIL b2b_write_reply: got %h expected 4b", tx_q[4]); end
      end
      checks++;
      if (txn_count !== base + 2) begin errors++; $display("FAIL b2b_ncyc: got %0d expected 2", txn_count - base); end
      checks++;
      if ({cap_adr, cap_dat} !== 64'h00000034_55AA55AA) begin
         errors++; $display("FAIL b2b_write: got %h_%h expected 00000034_55aa55aa", cap_adr, cap_dat);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      bit ok;
      // reset while the bus cycle is open
      ack_delay = -1;
      send_frame(72'h52_00000040, 5);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (wb_cyc_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge wb_clk_i);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_wb_cyc_seen: cyc %b expected 1", wb_cyc_o); end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, busy_o, uart_tx_o} !== 4'b0001 || wb_adr_o !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_wb: cyc/stb/busy/tx got %b adr %h expected 0001 adr 0",
                  {wb_cyc_o, wb_stb_o, busy_o, uart_tx_o}, wb_adr_o);
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (20) @(posedge wb_clk_i);
      // reset during the start bit of a reply byte
      ack_delay = 1;
      send_byte(8'h41, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge wb_clk_i);
         if (uart_tx_o === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_tx_start_seen: tx %b expected 0", uart_tx_o); end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      checks++;
      if ({wb_cyc_o, busy_o, uart_tx_o} !== 3'b001) begin
         errors++; $display("FAIL rst_mid_tx: cyc/busy/tx got %b expected 001", {wb_cyc_o, busy_o, uart_tx_o});
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (150) @(posedge wb_clk_i);
      clear_q();
      send_frame(72'h57_00000050_A5A5A5A5, 9);
      wait_reply(1, ok);
      checks++;
      if ({cap_adr, cap_dat, cap_we} !== {64'h00000050_A5A5A5A5, 1'b1}) begin
         errors++; $display("FAIL rst_next_write: got %h_%h we %b expected 00000050_a5a5a5a5 we 1", cap_adr, cap_dat, cap_we);
      end
      if (ok) begin
         checks++;
         if (tx_q[0] !== 8'h4B) begin errors++; $display("FAIL rst_next_reply: got %h expected 4b", tx_q[0]); end
      end
   endtask

   initial begin
      wb_rst_i  = 1'b1;
      uart_rx_i = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_unknown();
      test_ack_timeout();
      test_byte_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
